// File: rtl/c880_misr_if.sv
// Interface between the c880 response source and the signature compactor.
// The master drives the run controls and responses, the slave reports status and the signature.
interface c880_misr_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] num_patterns;
    logic             resp_valid;
    logic [25:0]      resp;
    logic [31:0]      expected_sig;
    logic             busy;
    logic             done;
    logic [31:0]      signature;
    logic             sig_valid;
    logic             match;

    modport master (
        output start, num_patterns, resp_valid, resp, expected_sig,
        input  busy, done, signature, sig_valid, match
    );

    modport slave (
        input  start, num_patterns, resp_valid, resp, expected_sig,
        output busy, done, signature, sig_valid, match
    );
endinterface

// File: rtl/c880_misr.sv
// 32-bit MISR that compacts a counted run of 26-bit c880 responses into a signature
// and compares the final value against a golden signature.
module c880_misr #(
    parameter logic [31:0] SEED  = 32'hFFFF_FFFF,
    parameter int          CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    c880_misr_if.slave  bus_io
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      sig_q, sig_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             sig_valid_q, sig_valid_d;
    logic             match_q, match_d;

    // Shift left, fold the feedback polynomial in on a carry-out, then inject the response.
    function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [25:0] resp);
        logic [31:0] fb;
        fb = sig[31] ? 32'h0040_0007 : 32'h0;
        return {sig[30:0], 1'b0} ^ fb ^ {6'b0, resp};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_io.start) begin
                    state_d = (bus_io.num_patterns == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus_io.resp_valid && (rem_q == CNT_W'(1))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_io.busy      = (state_q == ST_RUN);
        bus_io.done      = (state_q == ST_DONE);
        bus_io.signature = sig_q;
        bus_io.sig_valid = sig_valid_q;
        bus_io.match     = match_q;
    end

    // RUN is only entered with a nonzero count and left at 1, so rem_q never wraps.
    always_comb begin
        sig_d       = sig_q;
        rem_d       = rem_q;
        sig_valid_d = sig_valid_q;
        match_d     = match_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_io.start) begin
                    sig_d       = SEED;
                    rem_d       = bus_io.num_patterns;
                    sig_valid_d = 1'b0;
                    match_d     = 1'b0;
                end
            end
            ST_RUN: begin
                if (bus_io.resp_valid) begin
                    sig_d = misr_step(sig_q, bus_io.resp);
                    rem_d = rem_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                sig_valid_d = 1'b1;
                match_d     = (sig_q == bus_io.expected_sig);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q       <= 32'h0;
            rem_q       <= '0;
            sig_valid_q <= 1'b0;
            match_q     <= 1'b0;
        end else begin
            sig_q       <= sig_d;
            rem_q       <= rem_d;
            sig_valid_q <= sig_valid_d;
            match_q     <= match_d;
        end
    end
endmodule

// File: tb/tb_c880_misr.sv
// Directed bench for c880_misr: a default-SEED instance and a SEED=0 instance
// driven from one linear stimulus sequence with hand-computed signatures.
module tb_c880_misr;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    c880_misr_if #(.CNT_W(16)) a_if ();
    c880_misr_if #(.CNT_W(16)) z_if ();

    c880_misr #(.SEED(32'hFFFF_FFFF), .CNT_W(16)) dut_a (
        .clk    (clk),
        .rst    (rst),
        .bus_io (a_if.slave)
    );

    c880_misr #(.SEED(32'h0000_0000), .CNT_W(16)) dut_z (
        .clk    (clk),
        .rst    (rst),
        .bus_io (z_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    localparam logic [25:0] R1 = 26'h000_0001;
    localparam logic [25:0] R2 = 26'h2AA_AAAA;
    localparam logic [25:0] R3 = 26'h155_5555;
    localparam logic [31:0] S1 = 32'hFFBF_FFF8;
    localparam logic [31:0] S2 = 32'hFD95_555D;
    localparam logic [31:0] S3 = 32'hFA3F_FFE8;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        a_if.start = 1'b0; a_if.num_patterns = '0; a_if.resp_valid = 1'b0;
        a_if.resp = '0; a_if.expected_sig = '0;
        z_if.start = 1'b0; z_if.num_patterns = '0; z_if.resp_valid = 1'b0;
        z_if.resp = '0; z_if.expected_sig = '0;
        tick(); tick();

        chk("rst_busy", a_if.busy, 0);
        chk("rst_done", a_if.done, 0);
        chk("rst_sig", a_if.signature, 32'h0);
        chk("rst_sig_valid", a_if.sig_valid, 0);
        chk("rst_match", a_if.match, 0);
        chk("rst_sig_z", z_if.signature, 32'h0);
        rst = 1'b0;

        // Single-pattern run with a zero response.
        a_if.num_patterns = 16'd1; a_if.expected_sig = 32'hFFBF_FFF9; a_if.start = 1'b1;
        tick();
        chk("one_busy", a_if.busy, 1);
        chk("one_seed", a_if.signature, 32'hFFFF_FFFF);
        a_if.start = 1'b0; a_if.resp = '0; a_if.resp_valid = 1'b1;
        tick();
        chk("one_sig", a_if.signature, 32'hFFBF_FFF9);
        chk("one_done", a_if.done, 1);
        chk("one_busy_off", a_if.busy, 0);
        a_if.resp_valid = 1'b0;
        tick();
        chk("one_done_off", a_if.done, 0);
        chk("one_sig_valid", a_if.sig_valid, 1);
        chk("one_match", a_if.match, 1);

        // All-ones response from a zero seed, golden value deliberately wrong.
        z_if.num_patterns = 16'd1; z_if.expected_sig = 32'h0; z_if.start = 1'b1;
        tick();
        z_if.start = 1'b0; z_if.resp = 26'h3FF_FFFF; z_if.resp_valid = 1'b1;
        tick();
        chk("ones_sig", z_if.signature, 32'h03FF_FFFF);
        chk("ones_done", z_if.done, 1);
        z_if.resp_valid = 1'b0;
        tick();
        chk("ones_sig_valid", z_if.sig_valid, 1);
        chk("ones_match", z_if.match, 0);

        // Zero-length run goes straight to DONE.
        a_if.num_patterns = 16'd0; a_if.expected_sig = 32'hFFFF_FFFF; a_if.start = 1'b1;
        tick();
        chk("zero_done", a_if.done, 1);
        chk("zero_busy", a_if.busy, 0);
        chk("zero_sig", a_if.signature, 32'hFFFF_FFFF);
        chk("zero_sv_clr", a_if.sig_valid, 0);
        a_if.start = 1'b0;
        tick();
        chk("zero_busy2", a_if.busy, 0);
        chk("zero_sv", a_if.sig_valid, 1);
        chk("zero_match", a_if.match, 1);

        // Responses while IDLE must not touch the signature.
        a_if.resp = 26'h123_4567; a_if.resp_valid = 1'b1;
        tick(); tick(); tick();
        chk("idle_resp_sig", a_if.signature, 32'hFFFF_FFFF);
        chk("idle_resp_busy", a_if.busy, 0);
        a_if.resp_valid = 1'b0;

        // Gapped run (gaps 0, 2, 5) with stray start pulses inside RUN.
        a_if.num_patterns = 16'd3; a_if.expected_sig = S3; a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0; a_if.resp = R1; a_if.resp_valid = 1'b1;
        tick();
        chk("gap_s1", a_if.signature, S1);
        a_if.resp_valid = 1'b0; a_if.resp = 26'h3FF_FFFF; a_if.start = 1'b1;
        a_if.num_patterns = 16'd0;
        tick(); tick();
        chk("gap_hold_s1", a_if.signature, S1);
        chk("gap_start_ignored", a_if.busy, 1);
        a_if.start = 1'b0; a_if.resp = R2; a_if.resp_valid = 1'b1;
        tick();
        chk("gap_s2", a_if.signature, S2);
        a_if.resp_valid = 1'b0; a_if.resp = 26'h0AB_CDEF;
        for (int i = 0; i < 5; i++) begin
            a_if.start = (i == 2);
            tick();
        end
        chk("gap_hold_s2", a_if.signature, S2);
        chk("gap_busy_hold", a_if.busy, 1);
        a_if.start = 1'b0; a_if.resp = R3; a_if.resp_valid = 1'b1;
        tick();
        chk("gap_s3", a_if.signature, S3);
        chk("gap_done", a_if.done, 1);

        // In DONE: stray response and start are ignored.
        a_if.resp = 26'h3FF_FFFF; a_if.resp_valid = 1'b1;
        a_if.start = 1'b1; a_if.num_patterns = 16'd3;
        tick();
        chk("done_resp_ignored", a_if.signature, S3);
        chk("done_start_ignored", a_if.busy, 0);
        chk("gap_sv", a_if.sig_valid, 1);
        chk("gap_match", a_if.match, 1);

        // Start held into the cycle after DONE is accepted: reload and clear.
        a_if.resp_valid = 1'b0;
        tick();
        chk("restart_busy", a_if.busy, 1);
        chk("restart_sv", a_if.sig_valid, 0);
        chk("restart_match", a_if.match, 0);
        chk("restart_seed", a_if.signature, 32'hFFFF_FFFF);

        // Same three responses back to back give the same signature.
        a_if.start = 1'b0;
        a_if.resp = R1; a_if.resp_valid = 1'b1; tick();
        a_if.resp = R2; tick();
        a_if.resp = R3; tick();
        chk("nogap_s3", a_if.signature, S3);
        chk("nogap_done", a_if.done, 1);
        a_if.resp_valid = 1'b0;
        tick();

        // Reset after 2 of 4 responses discards the partial signature.
        a_if.num_patterns = 16'd4; a_if.start = 1'b1;
        tick();
        a_if.start = 1'b0;
        a_if.resp = R1; a_if.resp_valid = 1'b1; tick();
        a_if.resp = R2; tick();
        chk("mid_s2", a_if.signature, S2);
        rst = 1'b1; a_if.resp = R3;
        tick();
        chk("mid_rst_sig", a_if.signature, 32'h0);
        chk("mid_rst_busy", a_if.busy, 0);
        chk("mid_rst_done", a_if.done, 0);
        chk("mid_rst_sv", a_if.sig_valid, 0);
        chk("mid_rst_match", a_if.match, 0);
        rst = 1'b0; a_if.resp_valid = 1'b0;
        a_if.num_patterns = 16'd1; a_if.expected_sig = 32'hFFBF_FFF9; a_if.start = 1'b1;
        tick();
        chk("post_rst_seed", a_if.signature, 32'hFFFF_FFFF);
        a_if.start = 1'b0; a_if.resp = '0; a_if.resp_valid = 1'b1;
        tick();
        chk("post_rst_sig", a_if.signature, 32'hFFBF_FFF9);
        a_if.resp_valid = 1'b0;
        tick();
        chk("post_rst_match", a_if.match, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/c880_misr.md
C880_MISR -- requirements
Module: c880_misr

Interface
REQ-001 Parameter SEED, default 32'hFFFF_FFFF: signature value loaded when a run starts.
REQ-002 Parameter CNT_W, default 16: width of the pattern count.
REQ-003 clk  input  1: the single clock; all state updates on the rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 start  input  1: request to begin a compaction run.
REQ-006 num_patterns  input  CNT_W: number of responses in the run; sampled on the accepted start.
REQ-007 resp_valid  input  1: resp holds a valid c880 response this cycle.
REQ-008 resp  input  26: c880 output vector, bit 0 = N388 through bit 25 = N880, in declaration order.
REQ-009 expected_sig  input  32: golden signature for comparison.
REQ-010 busy  output  1: high in RUN.
REQ-011 done  output  1: one-cycle pulse in DONE.
REQ-012 signature  output  32: current MISR contents.
REQ-013 sig_valid  output  1: signature is final.
REQ-014 match  output  1: final signature equals expected_sig.

Function
REQ-015 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-016 In IDLE, start=1 SHALL load signature<=SEED, remaining<=num_patterns, clear sig_valid and match, and move to RUN, or to DONE if num_patterns==0.
REQ-017 In RUN, each cycle with resp_valid=1 SHALL update signature<={signature[30:0],1'b0} ^ (signature[31] ? 32'h0040_0007 : 0) ^ {6'b0,resp}, and decrement remaining.
REQ-018 In RUN, resp_valid=0 SHALL leave signature and remaining unchanged, with no timeout.
REQ-019 A resp_valid cycle with remaining==1 SHALL apply the update and move to DONE on the next edge.
REQ-020 DONE SHALL last exactly one cycle with done=1, set sig_valid<=1 and match<=(signature==expected_sig), then return to IDLE.
REQ-021 sig_valid and match SHALL hold through IDLE until the next accepted start.
REQ-022 start SHALL be ignored in RUN and DONE; resp_valid SHALL be ignored in IDLE and DONE.
REQ-023 busy SHALL be 1 exactly when the state is RUN; done SHALL be 1 exactly when the state is DONE.
REQ-024 The remaining counter SHALL be CNT_W bits and SHALL never wrap, since the run terminates at 1.
REQ-025 signature SHALL not change outside IDLE->start loads and RUN resp_valid cycles.
REQ-026 expected_sig SHALL be sampled only in the DONE cycle.

Reset
REQ-027 While rst=1 at an edge, the block SHALL go to IDLE with signature=32'h0, remaining=0, busy=0, done=0, sig_valid=0 and match=0.
REQ-028 rst SHALL take priority over start and resp_valid, including mid-run, in which case the partial signature is discarded.
REQ-029 After rst deasserts, the first start SHALL behave per REQ-016.

Verification
REQ-030 Single-pattern run:
- Stimulus: SEED default, num_patterns=1, start, then resp=0 with resp_valid=1.
- Required response: signature=32'hFFBF_FFF9, done pulses one cycle later, sig_valid=1; expected_sig=32'hFFBF_FFF9 gives match=1.
REQ-031 All-ones response:
- Stimulus: SEED=0, num_patterns=1, resp=26'h3FF_FFFF.
- Required response: signature=32'h03FF_FFFF, match=0 when expected_sig=0.
REQ-032 Zero-length run:
- Stimulus: num_patterns=0, start.
- Required response: DONE in the next cycle, busy never rises, signature=SEED.
REQ-033 Gapped responses:
- Stimulus: num_patterns=3, responses with resp_valid gaps of 0, 2 and 5 cycles.
- Required response: signature identical to a gapless run with the same 3 responses; start pulses during RUN are ignored.
REQ-034 Reset mid-run:
- Stimulus: rst asserted after 2 of 4 responses.
- Required response: all outputs 0 on the next edge; a new run then yields the fresh signature.
REQ-035 Out-of-state stimulus:
- Stimulus: resp_valid=1 while in IDLE, then a second start in the cycle after DONE.
- Required response: signature is unchanged while IDLE; the second start clears sig_valid and reloads SEED.
